// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory
// and hands {inst, pc, pc+PC_INC} to IF/ID through a 1-entry skid buffer.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] pc_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {S_FETCH = 1'b0, S_DROP = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
  } fetch_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        req_q, req_d;
  logic        out_vld_q, out_vld_d;
  fetch_t      out_q, out_d;
  logic        skid_vld_q, skid_vld_d;
  fetch_t      skid_q, skid_d;

  logic        ack_take;
  logic        consume;
  logic [31:0] pc_inc;
  logic [31:0] tgt;
  fetch_t      fetched;

  assign ack_take = req_q & imem_ack;
  assign consume  = out_vld_q & ~stall;
  assign pc_inc   = pc_q + PC_INC;
  assign tgt      = redirect_pc & ~32'h3;
  assign fetched  = '{inst: imem_rdata, pc: pc_q, pc_nxt: pc_inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      req_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    req_d      = req_q & ~ack_take;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;

    if (redirect) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      // An outstanding read cannot be cancelled: park the target until its ack.
      if (!req_q || ack_take) begin
        pc_d    = tgt;
        state_d = S_FETCH;
      end else begin
        pend_d  = tgt;
        state_d = S_DROP;
      end
    end else begin
      case (state_q)
        S_DROP: begin
          if (ack_take) begin
            pc_d    = pend_q;
            state_d = S_FETCH;
          end
        end
        default: begin
          if (consume) begin
            if (skid_vld_q) begin
              out_d      = skid_q;
              skid_vld_d = 1'b0;
            end else begin
              out_vld_d  = 1'b0;
            end
          end
          if (ack_take) begin
            pc_d = pc_inc;
            if (!out_vld_q || consume) begin
              out_vld_d = 1'b1;
              out_d     = fetched;
            end else begin
              skid_vld_d = 1'b1;
              skid_d     = fetched;
            end
          end
        end
      endcase
    end

    // New request only with room downstream and no redirect target to load.
    if (state_q == S_FETCH && !redirect && !skid_vld_d &&
        (!req_q || ack_take) && (!out_vld_q || !stall))
      req_d = 1'b1;
  end

  always_comb begin
    imem_req     = req_q;
    imem_addr    = pc_q;
    inst_valid   = out_vld_q;
    inst_out     = out_q.inst;
    pc_out       = out_q.pc;
    pc_plus4_out = out_q.pc_nxt;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (consume)            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_vld_q && stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect)           perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected memory
// transactions and deliveries; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] pc_out;

  int nchk = 0;
  int nfail = 0;
  int lat = 0;
  int acks = 0;
  int ack_limit = 0;
  int wcnt = 0;

  typedef struct {
    logic [31:0] addr;
    bit          chk;
    bit          dlv;
  } ent_t;

  ent_t        qa[$];
  logic [31:0] qo[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_plus4_out(pc_plus4_out), .pc_out(pc_out)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory: ack once the request has waited lat cycles and the ack budget allows.
  assign imem_ack   = imem_req && (wcnt >= lat) && (acks < ack_limit);
  assign imem_rdata = memf(imem_addr);

  always @(posedge clk) begin
    if (imem_req && imem_ack) begin
      acks <= acks + 1;
      wcnt <= 0;
    end else if (imem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input bit c, input bit d);
    ent_t e;
    e.addr = a; e.chk = c; e.dlv = d;
    qa.push_back(e);
    if (d) qo.push_back(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (qa.size() != 0 || qo.size() != 0); i++) step();
    chk("drain_pending", qa.size() + qo.size(), 0);
    repeat (4) step();
  endtask

  // Monitor
  initial begin
    logic        prev_req, prev_ack, pend;
    logic [31:0] prev_addr, pend_addr, e_pc;
    int          held;
    ent_t        e;
    prev_req = 0; prev_ack = 0; prev_addr = 0; pend = 0; pend_addr = 0; held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0; pend = 0; held = 0;
      end else begin
        if (pend) begin
          chk("load_next_cycle_vld", inst_valid, 1);
          chk("load_next_cycle_pc", pc_out, pend_addr);
          pend = 0;
        end
        if (prev_req && !prev_ack) begin
          chk("req_held", imem_req, 1);
          chk("addr_held", imem_addr, prev_addr);
        end
        held = imem_req ? held + 1 : 0;
        if (imem_req && imem_ack) begin
          if (qa.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
          else begin
            e = qa.pop_front();
            chk("fetch_addr", imem_addr, e.addr);
            if (e.chk) chk("fetch_latency", held, lat + 1);
            if (e.dlv && (!inst_valid || !stall) && !redirect) begin
              pend = 1; pend_addr = e.addr;
            end
          end
          held = 0;
        end
        if (inst_valid && !stall) begin
          if (qo.size() == 0) chk("unexpected_delivery", pc_out, 32'hDEAD_BEEF);
          else begin
            e_pc = qo.pop_front();
            chk("deliver_pc", pc_out, e_pc);
            chk("deliver_inst", inst_out, memf(e_pc));
            chk("deliver_pc_plus4", pc_plus4_out, e_pc + 32'd4);
          end
        end
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_vld", inst_valid, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc4", pc_plus4_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_addr", imem_addr, 0);

    // Zero-wait streaming from reset
    for (int i = 0; i < 8; i++) push(32'(i * 4), 1, 1);
    ack_limit = acks + 8;
    reset = 0;
    drain();

    // 3-cycle memory latency
    lat = 3;
    push(32'h20, 0, 1); push(32'h24, 1, 1); push(32'h28, 1, 1);
    ack_limit = acks + 3;
    drain();

    // Stall while a request is in flight: second word lands in the skid
    push(32'h2C, 0, 1); push(32'h30, 1, 1);
    ack_limit = acks + 2;
    step();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_vld", inst_valid, 1);
      chk("stall_hold_pc", pc_out, 32'h2C);
      chk("stall_hold_inst", inst_out, memf(32'h2C));
      if (i >= 3) chk("stall_no_req", imem_req, 0);
    end
    stall = 0;
    drain();

    // Redirect with nothing outstanding, while stalled with valid+skid full
    push(32'h34, 0, 0); push(32'h38, 1, 0);
    ack_limit = acks + 2;
    stall = 1;
    repeat (6) step();
    chk("full_vld", inst_valid, 1);
    chk("full_pc", pc_out, 32'h34);
    chk("full_no_req", imem_req, 0);
    redirect = 1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 0;
    chk("redir_flush_vld", inst_valid, 0);
    chk("redir_req_low", imem_req, 0);
    step();
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h100);
    stall = 0;
    push(32'h100, 1, 1);
    ack_limit = acks + 1;
    drain();

    // Redirects during an in-flight fetch: latest target wins, data dropped
    push(32'h104, 0, 0);
    redirect = 1; redirect_pc = 32'h10;
    step();
    redirect = 0;
    ack_limit = acks + 1;
    chk("drop_vld0", inst_valid, 0);
    step();
    chk("drop_done_req", imem_req, 0);
    step();
    chk("fetch10_req", imem_req, 1);
    chk("fetch10_addr", imem_addr, 32'h10);
    push(32'h10, 1, 0);
    ack_limit = acks + 1;
    redirect = 1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    chk("drop_vld1", inst_valid, 0);
    step();
    redirect = 0;
    chk("drop_vld2", inst_valid, 0);
    step();
    chk("drop_vld3", inst_valid, 0);
    chk("drop_addr_old", imem_addr, 32'h10);
    step();
    chk("drop_vld4", inst_valid, 0);
    chk("drop_req_low", imem_req, 0);
    step();
    chk("redir300_req", imem_req, 1);
    chk("redir300_addr", imem_addr, 32'h300);
    push(32'h300, 1, 1);
    ack_limit = acks + 1;
    drain();

    // PC wrap at the top of the address space
    push(32'h304, 0, 0);
    redirect = 1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 0;
    lat = 0;
    push(32'hFFFF_FFFC, 1, 1); push(32'h0, 1, 1);
    ack_limit = acks + 3;
    drain();

    // Async reset in the middle of a fetch from 0xFFFF_FFFC
    push(32'h4, 0, 0);
    lat = 3;
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    ack_limit = acks + 1;
    step();
    step();
    chk("top_req", imem_req, 1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    reset = 1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_vld", inst_valid, 0);
    chk("mid_rst_inst", inst_out, 0);
    chk("mid_rst_pc", pc_out, 0);
    chk("mid_rst_pc4", pc_plus4_out, 0);
    chk("mid_rst_addr", imem_addr, 0);
    step();
    step();
    reset = 0;
    step();
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    push(32'h0, 1, 1);
    ack_limit = acks + 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues req/ack reads to instruction memory, and presents {PC+4, instruction} with a valid flag for IF/ID to capture.
- Handles downstream stall with a 1-entry skid buffer and handles branch/jump redirect, including discard of in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, PC increment per sequential fetch in bytes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  read address; stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  read data valid; may assert in the same cycle as imem_req.
- imem_rdata  input  32  instruction word, sampled only when imem_req & imem_ack.
- stall  input  1  downstream cannot accept; outputs must hold.
- redirect  input  1  taken branch/jump; single-cycle pulse or level.
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- inst_valid  output  1  inst_out/pc_plus4_out hold a live instruction.
- inst_out  output  32  fetched instruction; feeds IF/ID inst_mem_data.
- pc_plus4_out  output  32  fetch PC + PC_INC; feeds IF/ID alu_data.
- pc_out  output  32  fetch PC of inst_out.

Behaviour:
- Reset (async): pc=RESET_PC, state=S_FETCH, imem_req=0, inst_valid=0, inst_out=0, pc_plus4_out=0, pc_out=0, skid empty, no pending redirect. Reset mid-transaction abandons it; any later ack is ignored until a new req is issued.
- Consume: the output is consumed at a posedge when inst_valid=1 and stall=0.
- States:
  - S_FETCH: normal operation.
  - S_DROP: in-flight fetch is discarded; holds the pending redirect target.
- Request rules:
  - imem_req rises only when the skid buffer is empty, there is no pending redirect to load, and (inst_valid=0 or stall=0).
  - Once high, imem_req and imem_addr are held until ack, irrespective of stall or redirect.
  - imem_addr = pc.
- Ack in S_FETCH (no redirect this cycle):
  - pc <= pc+PC_INC, mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - If the output is empty or being consumed: load outputs {imem_rdata, pc, pc+PC_INC} and set inst_valid=1. Latency from req to valid is 1 cycle after ack.
  - Otherwise write the skid buffer.
- Skid drain: when the output is consumed and the skid is full, the skid moves to the outputs that edge and the skid becomes empty.
- Redirect (highest priority, overrides stall):
  - inst_valid<=0, skid cleared.
  - If no req is outstanding, or ack arrives this cycle: pc<=redirect_pc, stay in S_FETCH, and discard the acked data.
  - Else latch redirect_pc into pending and go to S_DROP.
- S_DROP:
  - Req stays held on the old address.
  - A further redirect overwrites pending (latest wins).
  - On ack: discard data, pc<=pending, go to S_FETCH.
  - inst_valid stays 0 throughout.
- Redirect together with stall: the flush still occurs; the stall affects only held valid data.
- At most one outstanding request. The only full condition is output valid plus skid full, which blocks new requests.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_fetch_cnt[31:0]: increments per instruction delivered to the consumer.
  - perf_stall_cnt[31:0]: increments per cycle with inst_valid=1 and stall=1.
  - perf_flush_cnt[31:0]: increments per redirect cycle.
- All counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory (ack = req), stall=0 -> imem_addr 0,4,8,...; inst_out follows memory one cycle later; pc_plus4_out = pc_out+4.
- Memory ack latency of 3 cycles -> imem_addr held constant for 4 cycles; exactly one inst_valid pulse per ack.
- stall high for 5 cycles while a req is in flight -> skid captures the instruction, no new req is issued, outputs stay constant; after release, both instructions are delivered in order with no loss or duplication.
- redirect to 32'h0000_0103 with no outstanding req -> next imem_addr = 32'h0000_0100; inst_valid=0 for that cycle.
- redirect to 32'h200 during a 3-cycle-latency fetch of 0x10, then a second redirect to 32'h300 before ack -> ack for 0x10 is discarded, next imem_addr = 32'h300, no instruction from 0x10 or 0x200 is emitted.
- Assert reset with pc=32'hFFFF_FFFC mid-fetch; separately run a wrap test -> reset gives pc=RESET_PC with all outputs 0; the wrap run gives fetch from 32'hFFFF_FFFC then 32'h0, with pc_plus4_out=32'h0.
